// File: rtl/ecg_rpeak_detector.sv
// R-peak detector: drains Q31 ECG samples from fifo_sync, reports the maximum of each
// above-threshold excursion, then ignores a fixed number of samples (refractory window).
module ecg_rpeak_detector #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned INDEX_WIDTH     = 16,
  parameter int unsigned REFRACT_SAMPLES = 50,
  parameter int unsigned MAX_TRACK       = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cs,
  input  logic                         fifo_empty,
  input  logic signed [DATA_WIDTH-1:0] fifo_data,
  output logic                         fifo_rd_en,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  output logic                         peak_valid,
  output logic signed [DATA_WIDTH-1:0] peak_amp,
  output logic [INDEX_WIDTH-1:0]       peak_index,
  output logic [15:0]                  peak_count,
  output logic [1:0]                   state_dbg
);

  localparam int unsigned CNT_W = $clog2(MAX_TRACK + 2);
  localparam int unsigned REF_W = $clog2(REFRACT_SAMPLES + 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'b00,
    ST_TRACK   = 2'b01,
    ST_REFRACT = 2'b10
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic                           r_s_valid;
  logic [INDEX_WIDTH-1:0]         r_index;
  logic signed [DATA_WIDTH-1:0]   r_cand_amp;
  logic [INDEX_WIDTH-1:0]         r_cand_idx;
  logic [CNT_W-1:0]               r_track_cnt;
  logic [REF_W-1:0]               r_ref_cnt;
  logic                           r_peak_valid;
  logic signed [DATA_WIDTH-1:0]   r_peak_amp;
  logic [INDEX_WIDTH-1:0]         r_peak_index;
  logic [15:0]                    r_peak_count;

  logic                           w_above;
  logic                           w_gt_cand;
  logic [CNT_W-1:0]               w_track_inc;
  logic                           w_track_full;
  logic                           w_ref_last;
  logic                           w_emit;
  logic                           w_cand_load;
  logic                           w_cand_upd;
  logic                           w_track_step;
  logic                           w_ref_dec;
  logic signed [DATA_WIDTH-1:0]   w_emit_amp;
  logic [INDEX_WIDTH-1:0]         w_emit_idx;

  // Reads are held off while in reset so no sample is lost across reset release.
  assign fifo_rd_en   = cs & ~fifo_empty & rst_n;

  assign w_above      = fifo_data > threshold;
  assign w_gt_cand    = fifo_data > r_cand_amp;
  assign w_track_inc  = r_track_cnt + CNT_W'(1);
  assign w_track_full = (w_track_inc >= CNT_W'(MAX_TRACK));
  assign w_ref_last   = (r_ref_cnt == REF_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the FSM only moves on a consumed sample
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEARCH: begin
        if (r_s_valid && w_above) w_state_nxt = ST_TRACK;
      end
      ST_TRACK: begin
        if (r_s_valid && (!w_above || w_track_full)) w_state_nxt = ST_REFRACT;
      end
      ST_REFRACT: begin
        if (r_s_valid && w_ref_last) w_state_nxt = ST_SEARCH;
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_emit       = 1'b0;
    w_cand_load  = 1'b0;
    w_cand_upd   = 1'b0;
    w_track_step = 1'b0;
    w_ref_dec    = 1'b0;
    w_emit_amp   = r_cand_amp;
    w_emit_idx   = r_cand_idx;
    if (r_s_valid) begin
      case (r_state)
        ST_SEARCH:  w_cand_load = w_above;
        ST_TRACK: begin
          w_track_step = w_above;
          w_cand_upd   = w_above & w_gt_cand;
          w_emit       = ~w_above | w_track_full;
          // A forced report must include the sample that filled the window.
          if (w_cand_upd) begin
            w_emit_amp = fifo_data;
            w_emit_idx = r_index;
          end
        end
        ST_REFRACT: w_ref_dec = 1'b1;
        default: ;
      endcase
    end
  end

  // Read pipeline, sample index, candidate and refractory counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_valid   <= 1'b0;
      r_index     <= '0;
      r_cand_amp  <= '0;
      r_cand_idx  <= '0;
      r_track_cnt <= '0;
      r_ref_cnt   <= '0;
    end else begin
      r_s_valid <= fifo_rd_en;
      if (r_s_valid) r_index <= r_index + INDEX_WIDTH'(1);
      if (w_cand_load) begin
        r_cand_amp  <= fifo_data;
        r_cand_idx  <= r_index;
        r_track_cnt <= CNT_W'(1);
      end else if (w_track_step) begin
        r_track_cnt <= w_track_inc;
        if (w_cand_upd) begin
          r_cand_amp <= fifo_data;
          r_cand_idx <= r_index;
        end
      end
      if (w_emit) begin
        r_ref_cnt <= REF_W'(REFRACT_SAMPLES);
      end else if (w_ref_dec) begin
        r_ref_cnt <= r_ref_cnt - REF_W'(1);
      end
    end
  end

  // Peak report registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak_valid <= 1'b0;
      r_peak_amp   <= '0;
      r_peak_index <= '0;
      r_peak_count <= '0;
    end else begin
      r_peak_valid <= w_emit;
      if (w_emit) begin
        r_peak_amp   <= w_emit_amp;
        r_peak_index <= w_emit_idx;
        if (r_peak_count != 16'hFFFF) r_peak_count <= r_peak_count + 16'd1;
      end
    end
  end

  assign peak_valid = r_peak_valid;
  assign peak_amp   = r_peak_amp;
  assign peak_index = r_peak_index;
  assign peak_count = r_peak_count;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_ecg_rpeak_detector.sv
// Directed bench for ecg_rpeak_detector: two instances (default and small parameters)
// share a simple fifo_sync model; each enabled in turn via its cs.
module tb_ecg_rpeak_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0, rst_n1, cs0, cs1, force_empty;
  logic signed [31:0] thr;
  logic signed [31:0] fifo_data = '0;
  logic fifo_empty, rd0, rd1, pv0, pv1;
  logic signed [31:0] amp0, amp1;
  logic [15:0] idx0;
  logic [3:0]  idx1;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  st0, st1;

  logic signed [31:0] mem [0:255];
  int wp = 0;
  int rp = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  logic signed [31:0] pamp0[$], pamp1[$];
  int pidx0[$], pidx1[$], pcyc0[$], pcyc1[$], rdc0[$], rdc1[$];

  ecg_rpeak_detector dut0 (
    .clk(clk), .rst_n(rst_n0), .cs(cs0), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd0), .threshold(thr), .peak_valid(pv0), .peak_amp(amp0),
    .peak_index(idx0), .peak_count(cnt0), .state_dbg(st0)
  );

  ecg_rpeak_detector #(
    .DATA_WIDTH(32), .INDEX_WIDTH(4), .REFRACT_SAMPLES(4), .MAX_TRACK(3)
  ) dut1 (
    .clk(clk), .rst_n(rst_n1), .cs(cs1), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(rd1), .threshold(thr), .peak_valid(pv1), .peak_amp(amp1),
    .peak_index(idx1), .peak_count(cnt1), .state_dbg(st1)
  );

  // fifo_sync model: data appears one cycle after rd_en is sampled
  assign fifo_empty = (wp == rp) || force_empty;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) rdc0.push_back(cyc);
    if (rd1) rdc1.push_back(cyc);
    if (rd0 || rd1) begin
      fifo_data <= mem[8'(rp)];
      rp <= rp + 1;
    end
  end

  always @(negedge clk) begin
    if (pv0) begin
      pamp0.push_back(amp0); pidx0.push_back(int'(idx0)); pcyc0.push_back(cyc);
    end
    if (pv1) begin
      pamp1.push_back(amp1); pidx1.push_back(int'(idx1)); pcyc1.push_back(cyc);
    end
  end

  task automatic push(input logic signed [31:0] v);
    mem[8'(wp)] = v;
    wp = wp + 1;
  endtask

  task automatic clear_logs();
    pamp0.delete(); pidx0.delete(); pcyc0.delete(); rdc0.delete();
    pamp1.delete(); pidx1.delete(); pcyc1.delete(); rdc1.delete();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (wp != rp && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wp != rp) begin
      errors++;
      $display("FAIL %s_drain: remaining=%0d required=0", nm, wp - rp);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_rst(input int which);
    @(negedge clk);
    if (which == 0) rst_n0 = 1'b0; else rst_n1 = 1'b0;
    @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (pv0 !== 1'b0) begin errors++; $display("FAIL rst_pv: got %0b want 0", pv0); end
    checks++; if (amp0 !== 32'sd0) begin errors++; $display("FAIL rst_amp: got %0d want 0", amp0); end
    checks++; if (idx0 !== 16'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", idx0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", cnt0); end
    checks++; if (st0 !== 2'b00) begin errors++; $display("FAIL rst_state: got %0b want 00", st0); end
    checks++; if (st1 !== 2'b00) begin errors++; $display("FAIL rst_state1: got %0b want 00", st1); end
    @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
  endtask

  task automatic test_basic();
    int lat, gap;
    clear_logs();
    thr = 32'sd1000;
    cs0 = 1'b1;
    push(0); push(500); push(1500); push(3000); push(2000); push(800);
    drain("t2");
    lat = (pcyc0.size() > 0 && rdc0.size() == 6) ? pcyc0[0] - rdc0[5] : -1;
    gap = (rdc0.size() == 6) ? rdc0[5] - rdc0[0] : -1;
    checks++; if (pamp0.size() !== 1) begin errors++; $display("FAIL t2_npeaks: got %0d want 1", pamp0.size()); end
    checks++; if (((pamp0.size() > 0) ? pamp0[0] : 32'sh7fffffff) !== 32'sd3000) begin
      errors++; $display("FAIL t2_amp: got %0d want 3000", (pamp0.size() > 0) ? pamp0[0] : 32'sh7fffffff); end
    checks++; if (((pidx0.size() > 0) ? pidx0[0] : -1) !== 3) begin
      errors++; $display("FAIL t2_idx: got %0d want 3", (pidx0.size() > 0) ? pidx0[0] : -1); end
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL t2_count: got %0d want 1", cnt0); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL t2_latency: got %0d want 2", lat); end
    checks++; if (gap !== 5) begin errors++; $display("FAIL t2_b2b: got %0d want 5", gap); end
    checks++; if (st0 !== 2'b10) begin errors++; $display("FAIL t2_state: got %0b want 10", st0); end
  endtask

  task automatic test_reset_mid();
    pulse_rst(0);
    thr = 32'sd1000;
    push(0); push(5000); push(6000);
    drain("t1a");
    checks++; if (st0 !== 2'b01) begin errors++; $display("FAIL t1_track: got %0b want 01", st0); end
    rst_n0 = 1'b0;
    push(0);
    #1;
    checks++; if (st0 !== 2'b00) begin errors++; $display("FAIL t1_state: got %0b want 00", st0); end
    checks++; if (pv0 !== 1'b0) begin errors++; $display("FAIL t1_pv: got %0b want 0", pv0); end
    checks++; if (amp0 !== 32'sd0) begin errors++; $display("FAIL t1_amp: got %0d want 0", amp0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL t1_cnt: got %0d want 0", cnt0); end
    checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL t1_rd: got %0b want 0", rd0); end
    @(negedge clk);
    rst_n0 = 1'b1;
    drain("t1b");
    checks++; if (pamp0.size() !== 0) begin errors++; $display("FAIL t1_nopeak: got %0d want 0", pamp0.size()); end
    checks++; if (st0 !== 2'b00) begin errors++; $display("FAIL t1_after: got %0b want 00", st0); end
  endtask

  task automatic test_gaps();
    logic signed [31:0] v [6];
    v = '{32'sd0, 32'sd500, 32'sd1500, 32'sd3000, 32'sd2000, 32'sd800};
    pulse_rst(0);
    thr = 32'sd1000;
    for (int i = 0; i < 6; i++) begin
      force_empty = 1'b1;
      cs0 = 1'b1;
      push(v[i]);
      @(negedge clk); #1;
      checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL t5_empty_rd%0d: got %0b want 0", i, rd0); end
      force_empty = 1'b0;
      cs0 = 1'b0;
      @(negedge clk); #1;
      checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL t5_cs_rd%0d: got %0b want 0", i, rd0); end
      cs0 = 1'b1;
      @(negedge clk);
      cs0 = 1'b0;
      @(negedge clk);
    end
    cs0 = 1'b1;
    drain("t5");
    checks++; if (rdc0.size() !== 6) begin errors++; $display("FAIL t5_reads: got %0d want 6", rdc0.size()); end
    checks++; if (pamp0.size() !== 1) begin errors++; $display("FAIL t5_npeaks: got %0d want 1", pamp0.size()); end
    checks++; if (((pamp0.size() > 0) ? pamp0[0] : 32'sh7fffffff) !== 32'sd3000) begin
      errors++; $display("FAIL t5_amp: got %0d want 3000", (pamp0.size() > 0) ? pamp0[0] : 32'sh7fffffff); end
    checks++; if (((pidx0.size() > 0) ? pidx0[0] : -1) !== 3) begin
      errors++; $display("FAIL t5_idx: got %0d want 3", (pidx0.size() > 0) ? pidx0[0] : -1); end
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL t5_count: got %0d want 1", cnt0); end
    cs0 = 1'b0;
  endtask

  task automatic test_refract();
    cs1 = 1'b1;
    pulse_rst(1);
    thr = 32'sd1000;
    push(0); push(2000); push(0); push(5000); push(5000);
    push(5000); push(5000); push(0); push(1500); push(0);
    drain("t3");
    checks++; if (pamp1.size() !== 2) begin errors++; $display("FAIL t3_npeaks: got %0d want 2", pamp1.size()); end
    checks++; if (((pamp1.size() > 0) ? pamp1[0] : 32'sh7fffffff) !== 32'sd2000) begin
      errors++; $display("FAIL t3_amp0: got %0d want 2000", (pamp1.size() > 0) ? pamp1[0] : 32'sh7fffffff); end
    checks++; if (((pidx1.size() > 0) ? pidx1[0] : -1) !== 1) begin
      errors++; $display("FAIL t3_idx0: got %0d want 1", (pidx1.size() > 0) ? pidx1[0] : -1); end
    checks++; if (((pamp1.size() > 1) ? pamp1[1] : 32'sh7fffffff) !== 32'sd1500) begin
      errors++; $display("FAIL t3_amp1: got %0d want 1500", (pamp1.size() > 1) ? pamp1[1] : 32'sh7fffffff); end
    checks++; if (((pidx1.size() > 1) ? pidx1[1] : -1) !== 8) begin
      errors++; $display("FAIL t3_idx1: got %0d want 8", (pidx1.size() > 1) ? pidx1[1] : -1); end
    checks++; if (cnt1 !== 16'd2) begin errors++; $display("FAIL t3_count: got %0d want 2", cnt1); end
  endtask

  task automatic test_forced();
    int lat;
    pulse_rst(1);
    thr = 32'sd0;
    push(10); push(20); push(20); push(30); push(-5);
    drain("t4");
    lat = (pcyc1.size() > 0 && rdc1.size() > 2) ? pcyc1[0] - rdc1[2] : -1;
    checks++; if (pamp1.size() !== 1) begin errors++; $display("FAIL t4_npeaks: got %0d want 1", pamp1.size()); end
    checks++; if (((pamp1.size() > 0) ? pamp1[0] : 32'sh7fffffff) !== 32'sd20) begin
      errors++; $display("FAIL t4_amp: got %0d want 20", (pamp1.size() > 0) ? pamp1[0] : 32'sh7fffffff); end
    checks++; if (((pidx1.size() > 0) ? pidx1[0] : -1) !== 1) begin
      errors++; $display("FAIL t4_idx: got %0d want 1", (pidx1.size() > 0) ? pidx1[0] : -1); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL t4_latency: got %0d want 2", lat); end
  endtask

  task automatic test_wrap_neg();
    pulse_rst(1);
    thr = -32'sd100;
    for (int i = 0; i < 17; i++) push(-200);
    push(-50);
    push(-300);
    drain("t6");
    checks++; if (pamp1.size() !== 1) begin errors++; $display("FAIL t6_npeaks: got %0d want 1", pamp1.size()); end
    checks++; if (((pamp1.size() > 0) ? pamp1[0] : 32'sh7fffffff) !== -32'sd50) begin
      errors++; $display("FAIL t6_amp: got %0d want -50", (pamp1.size() > 0) ? pamp1[0] : 32'sh7fffffff); end
    checks++; if (((pidx1.size() > 0) ? pidx1[0] : -1) !== 1) begin
      errors++; $display("FAIL t6_idx: got %0d want 1", (pidx1.size() > 0) ? pidx1[0] : -1); end
    checks++; if (cnt1 !== 16'd1) begin errors++; $display("FAIL t6_count: got %0d want 1", cnt1); end
    cs1 = 1'b0;
  endtask

  initial begin
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    cs0 = 1'b0;
    cs1 = 1'b0;
    force_empty = 1'b0;
    thr = 32'sd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_reset_mid();
    test_gaps();
    test_refract();
    test_forced();
    test_wrap_neg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
